// File: rtl/voice_key_alloc_if.sv
// Event-in / voice-load-out bundle between the note event source and the allocator.
interface voice_key_alloc_if #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) ();
  logic               ev_valid;
  logic               ev_ready;
  logic               ev_on;
  logic [6:0]         ev_key;
  logic               all_notes_off;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic               note_on;
  logic               steal;
  logic [VOICES-1:0]  voice_active;

  modport master (
    output ev_valid, ev_on, ev_key, all_notes_off,
    input  ev_ready, cur_key_adr, cur_key_val, note_on, steal, voice_active
  );

  modport slave (
    input  ev_valid, ev_on, ev_key, all_notes_off,
    output ev_ready, cur_key_adr, cur_key_val, note_on, steal, voice_active
  );
endinterface

// File: rtl/voice_key_alloc.sv
// Voice allocator: turns note-on/off events into per-voice key loads.
// Each voice keeps active/key/age; note-on retriggers, takes a free voice,
// or steals the oldest one.

// One voice table entry.
module voice_key_alloc_slot #(
  parameter int AGE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_bump,
  input  logic [6:0]       i_key,
  output logic             o_active,
  output logic [6:0]       o_key,
  output logic [AGE_W-1:0] o_age
);
  logic             r_active;
  logic [6:0]       r_key;
  logic [AGE_W-1:0] r_age;

  // clear beats load beats aging; age saturates so a long-held voice stays oldest
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_key    <= '0;
      r_age    <= '0;
    end else if (i_clr) begin
      r_active <= 1'b0;
      r_age    <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_key    <= i_key;
      r_age    <= '0;
    end else if (i_bump && r_active && (r_age != '1)) begin
      r_age    <= r_age + 1'b1;
    end
  end

  assign o_active = r_active;
  assign o_key    = r_key;
  assign o_age    = r_age;
endmodule

module voice_key_alloc #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int AGE_W   = 8
) (
  input logic              reg_clk,
  input logic              reset_reg,
  voice_key_alloc_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_SETUP, ST_STROBE} state_t;

  state_t                       r_state, w_nxt;
  logic                         r_ev_ready, r_pending;
  logic                         r_ev_on, r_tgt_steal;
  logic                         r_note_on, r_steal;
  logic [6:0]                   r_ev_key;
  logic [V_WIDTH-1:0]           r_cur_key_adr;
  logic [7:0]                   r_cur_key_val;

  logic [VOICES-1:0]            w_act, w_clr, w_load;
  logic [VOICES-1:0][6:0]       w_key;
  logic [VOICES-1:0][AGE_W-1:0] w_age;
  logic                         w_hs, w_hit, w_free, w_pend_nxt, w_clr_all, w_bump;
  logic [V_WIDTH-1:0]           w_hit_idx, w_free_idx, w_old_idx, w_tgt;
  logic [AGE_W-1:0]             w_old_age;

  assign w_hs       = bus.ev_valid && r_ev_ready;
  // a pending all-off survives until the allocator is back in IDLE
  assign w_pend_nxt = bus.all_notes_off || (r_pending && (r_state != ST_IDLE));
  assign w_clr_all  = (r_state == ST_IDLE) && r_pending;
  assign w_bump     = (r_state == ST_STROBE);

  // table search: lowest-index key match, lowest-index free voice, oldest voice
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_old_idx  = '0;
    w_old_age  = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (w_act[v] && (w_key[v] == r_ev_key)) begin
        w_hit     = 1'b1;
        w_hit_idx = V_WIDTH'(v);
      end
      if (!w_act[v]) begin
        w_free     = 1'b1;
        w_free_idx = V_WIDTH'(v);
      end
    end
    for (int v = 0; v < VOICES; v++) begin
      if (w_age[v] > w_old_age) begin
        w_old_age = w_age[v];
        w_old_idx = V_WIDTH'(v);
      end
    end
    w_tgt = w_hit ? w_hit_idx : (w_free ? w_free_idx : w_old_idx);
  end

  // next-state: IDLE -> SCAN -> (SETUP -> STROBE ->) IDLE
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!r_pending && w_hs) w_nxt = ST_SCAN;
      ST_SCAN:   w_nxt = r_ev_on ? ST_SETUP : ST_IDLE;
      ST_SETUP:  w_nxt = ST_STROBE;
      ST_STROBE: w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) r_state <= ST_IDLE;
    else           r_state <= w_nxt;
  end

  // ready is registered from the next state so it is low in reset and while an all-off waits
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      r_ev_ready <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_ev_ready <= (w_nxt == ST_IDLE) && !w_pend_nxt;
      r_pending  <= w_pend_nxt;
    end
  end

  // capture the event on handshake; the source may change it afterwards
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      r_ev_on  <= 1'b0;
      r_ev_key <= '0;
    end else if (w_hs) begin
      r_ev_on  <= bus.ev_on;
      r_ev_key <= bus.ev_key;
    end
  end

  // address/data settle in SETUP, a full cycle ahead of the strobe
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      r_cur_key_adr <= '0;
      r_cur_key_val <= 8'hFF;
      r_tgt_steal   <= 1'b0;
    end else if ((r_state == ST_SCAN) && r_ev_on) begin
      r_cur_key_adr <= w_tgt;
      r_cur_key_val <= {1'b0, r_ev_key};
      r_tgt_steal   <= !w_hit && !w_free;
    end
  end

  // one-cycle load strobe (and steal flag) for the STROBE cycle
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      r_note_on <= 1'b0;
      r_steal   <= 1'b0;
    end else begin
      r_note_on <= (r_state == ST_SETUP);
      r_steal   <= (r_state == ST_SETUP) && r_tgt_steal;
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    assign w_clr[v]  = w_clr_all ||
                       ((r_state == ST_SCAN) && !r_ev_on && w_hit && (w_hit_idx == V_WIDTH'(v)));
    assign w_load[v] = (r_state == ST_STROBE) && (r_cur_key_adr == V_WIDTH'(v));

    voice_key_alloc_slot #(.AGE_W(AGE_W)) u_slot (
      .i_clk    (reg_clk),
      .i_rst    (reset_reg),
      .i_clr    (w_clr[v]),
      .i_load   (w_load[v]),
      .i_bump   (w_bump),
      .i_key    (r_ev_key),
      .o_active (w_act[v]),
      .o_key    (w_key[v]),
      .o_age    (w_age[v])
    );
  end

  assign bus.ev_ready     = r_ev_ready;
  assign bus.cur_key_adr  = r_cur_key_adr;
  assign bus.cur_key_val  = r_cur_key_val;
  assign bus.note_on      = r_note_on;
  assign bus.steal        = r_steal;
  assign bus.voice_active = w_act;
endmodule

// File: tb/tb_voice_key_alloc.sv
// Bench for voice_key_alloc: transaction-level voice table model, per-cycle compare.
module tb_voice_key_alloc;
  localparam int NV = 8;
  localparam int AMAX = 255;

  logic clk = 1'b0;
  logic reset_reg;
  always #5 clk = ~clk;

  voice_key_alloc_if #(.VOICES(NV), .V_WIDTH(3)) vif ();

  voice_key_alloc #(.VOICES(NV), .V_WIDTH(3), .AGE_W(8)) dut (
    .reg_clk   (clk),
    .reset_reg (reset_reg),
    .bus       (vif.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model: voice table plus the expected value of each output this cycle
  bit       m_act [NV];
  int       m_key [NV];
  int       m_age [NV];
  bit       exp_ready;
  int       exp_adr;
  logic [7:0] exp_val;
  bit       exp_non;
  bit       exp_steal;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [NV-1:0] act_vec();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_act[v];
    return r;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin m_act[v] = 0; m_key[v] = 0; m_age[v] = 0; end
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < NV; v++) begin m_act[v] = 0; m_age[v] = 0; end
  endfunction

  // retrigger same key, else lowest free, else oldest (lowest index on tie)
  function automatic void model_pick(input int k, output int t, output bit s);
    t = -1; s = 0;
    for (int v = 0; v < NV; v++) if (t < 0 && m_act[v] && m_key[v] == k) t = v;
    for (int v = 0; v < NV; v++) if (t < 0 && !m_act[v]) t = v;
    if (t < 0) begin
      t = 0; s = 1;
      for (int v = 1; v < NV; v++) if (m_age[v] > m_age[t]) t = v;
    end
  endfunction

  function automatic void model_load(input int t, input int k);
    for (int v = 0; v < NV; v++) begin
      if (v == t) begin m_act[v] = 1; m_key[v] = k; m_age[v] = 0; end
      else if (m_act[v] && m_age[v] < AMAX) m_age[v]++;
    end
  endfunction

  function automatic void model_off(input int k);
    int t = -1;
    for (int v = 0; v < NV; v++) if (t < 0 && m_act[v] && m_key[v] == k) t = v;
    if (t >= 0) begin m_act[t] = 0; m_age[t] = 0; end
  endfunction

  // every cycle: all outputs against the model
  always @(negedge clk) begin
    chk("ev_ready", 32'(vif.ev_ready), 32'(exp_ready));
    chk("cur_key_adr", 32'(vif.cur_key_adr), 32'(exp_adr));
    chk("cur_key_val", 32'(vif.cur_key_val), 32'(exp_val));
    chk("note_on", 32'(vif.note_on), 32'(exp_non));
    chk("steal", 32'(vif.steal), 32'(exp_steal));
    chk("voice_active", 32'(vif.voice_active), 32'(act_vec()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    vif.ev_key = 7'($urandom);
    vif.ev_on  = 1'($urandom);
  endtask

  // note-on; ao = 1/2/3 pulses all_notes_off during SCAN/SETUP/STROBE
  task automatic op_on(input int k, input int ao, output int tgt, output bit st);
    int t; bit s;
    model_pick(k, t, s);
    tgt = t; st = s;
    vif.ev_valid = 1; vif.ev_on = 1; vif.ev_key = 7'(k);
    tick(); vif.ev_valid = 0; scramble(); exp_ready = 0;
    vif.all_notes_off = (ao == 1);
    tick(); exp_adr = t; exp_val = {1'b0, 7'(k)};
    vif.all_notes_off = (ao == 2);
    tick(); exp_non = 1; exp_steal = s;
    vif.all_notes_off = (ao == 3);
    tick(); vif.all_notes_off = 0; exp_non = 0; exp_steal = 0; model_load(t, k);
    if (ao != 0) begin tick(); model_clear(); end
    exp_ready = 1;
  endtask

  task automatic op_off(input int k, input bit ao);
    vif.ev_valid = 1; vif.ev_on = 0; vif.ev_key = 7'(k);
    tick(); vif.ev_valid = 0; scramble(); exp_ready = 0;
    vif.all_notes_off = ao;
    tick(); vif.all_notes_off = 0; model_off(k);
    if (ao) begin tick(); model_clear(); end
    exp_ready = 1;
  endtask

  task automatic op_alloff_idle();
    vif.all_notes_off = 1;
    tick(); vif.all_notes_off = 0; exp_ready = 0;
    tick(); model_clear(); exp_ready = 1;
  endtask

  // note-on interrupted by reset in SETUP: no strobe, immediate reset values
  task automatic op_on_reset(input int k);
    vif.ev_valid = 1; vif.ev_on = 1; vif.ev_key = 7'(k);
    tick(); vif.ev_valid = 0; scramble(); exp_ready = 0;
    tick();
    reset_reg = 1;
    exp_adr = 0; exp_val = 8'hFF; exp_non = 0; exp_steal = 0; model_reset();
    #1;
    chk("rst_now_note_on", 32'(vif.note_on), 32'd0);
    chk("rst_now_adr", 32'(vif.cur_key_adr), 32'd0);
    chk("rst_now_val", 32'(vif.cur_key_val), 32'hFF);
    chk("rst_now_active", 32'(vif.voice_active), 32'd0);
    chk("rst_now_ready", 32'(vif.ev_ready), 32'd0);
    tick(); tick();
    reset_reg = 0;
    tick(); exp_ready = 1;
  endtask

  initial begin
    int t; bit s;
    reset_reg = 1;
    vif.ev_valid = 0; vif.ev_on = 0; vif.ev_key = '0; vif.all_notes_off = 0;
    exp_ready = 0; exp_adr = 0; exp_val = 8'hFF; exp_non = 0; exp_steal = 0;
    model_reset();
    tick(); tick();
    chk("reset_val", 32'(vif.cur_key_val), 32'hFF);
    chk("reset_ready", 32'(vif.ev_ready), 32'd0);
    reset_reg = 0;
    tick(); exp_ready = 1;

    // first note lands in voice 0
    op_on(60, 0, t, s);
    chk("pin_tgt_60", t, 0); chk("pin_st_60", 32'(s), 0);
    chk("lit_val_60", 32'(vif.cur_key_val), 32'h3C);
    chk("lit_act_60", 32'(vif.voice_active), 32'h01);

    // fill voices 0..7
    for (int k = 60; k < 68; k++) op_on(k, 0, t, s);
    chk("pin_tgt_67", t, 7);
    chk("lit_act_full", 32'(vif.voice_active), 32'hFF);

    // steal the oldest (voice 0)
    op_on(70, 0, t, s);
    chk("pin_tgt_70", t, 0); chk("pin_st_70", 32'(s), 1);
    chk("lit_val_70", 32'(vif.cur_key_val), 32'h46);

    // retrigger voice 2
    op_on(62, 0, t, s);
    chk("pin_tgt_62", t, 2); chk("pin_st_62", 32'(s), 0);
    chk("lit_act_retrig", 32'(vif.voice_active), 32'hFF);

    // note-off voice 1, key outputs hold
    op_off(61, 0);
    chk("lit_act_off61", 32'(vif.voice_active), 32'hFD);
    chk("lit_adr_hold", 32'(vif.cur_key_adr), 32'd2);
    chk("lit_val_hold", 32'(vif.cur_key_val), 32'h3E);

    op_on(72, 0, t, s);
    chk("pin_tgt_72", t, 1);
    op_off(99, 0);
    chk("lit_act_off99", 32'(vif.voice_active), 32'hFF);

    op_alloff_idle();
    chk("lit_act_alloff", 32'(vif.voice_active), 32'h00);

    // age saturation: voices 0 and 1 both reach the ceiling, tie goes to voice 0
    for (int k = 60; k < 68; k++) op_on(k, 0, t, s);
    repeat (249) op_on(67, 0, t, s);
    op_on(90, 0, t, s);
    chk("pin_tgt_sat", t, 0); chk("pin_st_sat", 32'(s), 1);

    // all-off in SETUP: strobe completes, then the table clears
    op_on(91, 2, t, s);
    chk("lit_act_alloff_setup", 32'(vif.voice_active), 32'h00);

    op_on_reset(50);

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) op_alloff_idle();
      else if (r < 10) op_on(int'($urandom_range(58, 69)),
                             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0, t, s);
      else if (r < 18) op_off(int'($urandom_range(56, 71)), $urandom_range(0, 9) == 0);
      else if (r == 18) op_on_reset(int'($urandom_range(0, 127)));
      else repeat ($urandom_range(1, 3)) begin scramble(); tick(); end
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_key_alloc.md
Name: voice_key_alloc

Overview:
- Converts incoming note-on/note-off events into per-voice key assignments for the pitch datapath.
- Keeps a voice table holding active flag, key and age for each voice. Allocates a free voice, retriggers a voice already playing the same key, or steals the oldest voice.
- Drives cur_key_adr / cur_key_val and the one-cycle note_on strobe that loads the pitch block's per-voice key register. voice_active feeds envelope gating.

Parameters:
VOICES, 8, number of voices
V_WIDTH, 3, voice index width (log2 VOICES)
AGE_W, 8, width of per-voice saturating age counter

Ports:
reg_clk  in  1  system register clock, all logic on rising edge
reset_reg  in  1  asynchronous, active-high reset
ev_valid  in  1  event present
ev_ready  out  1  event accepted when ev_valid && ev_ready
ev_on  in  1  1 = note-on, 0 = note-off
ev_key  in  7  MIDI key number
all_notes_off  in  1  single-cycle request to clear every voice
cur_key_adr  out  V_WIDTH  voice being loaded
cur_key_val  out  8  key value for that voice, {1'b0, key}
note_on  out  1  one-cycle load strobe
steal  out  1  one-cycle pulse, coincident with note_on, when an active voice was stolen
voice_active  out  VOICES  per-voice gate

Behaviour:
- Reset values (asynchronous, while reset_reg high): cur_key_adr=0, cur_key_val=8'hFF, note_on=0, steal=0, voice_active=0, ev_ready=0, all keys=0, all ages=0, pending all-off cleared, FSM=IDLE. ev_ready rises in the first cycle after reset deasserts.
- FSM states: IDLE, SCAN, SETUP, STROBE.
- IDLE:
  - ev_ready=1 unless a pending all-off exists.
  - Pending all-off: clear all active flags and ages, clear pending, ev_ready=0 that cycle, stay in IDLE.
  - Else on handshake: latch ev_on/ev_key, go to SCAN.
- SCAN (one cycle), searching the registered table. Search priority for note-on:
  - (a) an active voice with key==ev_key is retriggered, steal=0;
  - (b) otherwise the lowest-index inactive voice;
  - (c) otherwise the voice with maximum age, ties going to the lowest index, steal=1.
- SCAN for note-off: the lowest-index active voice with key==ev_key has its active flag cleared and age zeroed, then return to IDLE. No strobe. cur_key_* are unchanged, so pitch holds through release. A note-off with no match returns to IDLE and has no effect.
- SCAN for note-on: latch the target index and steal flag, go to SETUP.
- SETUP: cur_key_adr=target, cur_key_val={1'b0,key}. Go to STROBE.
- STROBE:
  - note_on=1 for exactly one cycle, with address and data stable since SETUP. steal pulses with it if latched.
  - Table update: target active=1, key=ev_key, age=0. Every other active voice increments age, saturating at 2^AGE_W-1.
  - Return to IDLE.
- cur_key_adr and cur_key_val hold between loads.
- Latency: note-on handshake in cycle T gives cur_key_* valid at T+2, note_on at T+3, ev_ready at T+4. A note-off handshake at T gives the voice_active bit cleared at T+2 and ev_ready at T+2.
- all_notes_off arriving outside IDLE sets the pending flag. It is executed at the next IDLE and takes priority over ev_valid there. all_notes_off asserted in IDLE is executed the following cycle.
- voice_active changes only in STROBE, in a note-off SCAN, or on an all-off.
- Reset mid-operation aborts the sequence immediately to reset values. No partial strobe may appear.
- An event is never dropped: ev_ready stays low while busy, and ev_valid/ev_key must be held by the source until accepted.

Test Plan:
- Reset, then note-on key 60 → cur_key_adr=0, cur_key_val=8'h3C at T+2; note_on one cycle at T+3; voice_active=8'h01; steal=0.
- Note-ons for keys 60..67 → voices 0..7 in order, voice_active=8'hFF. Then note-on key 70 → voice 0 stolen (age 7, the maximum), steal=1, cur_key_val=8'h46.
- Voice 2 holds key 62; note-on key 62 again → retrigger voice 2, steal=0, voice_active unchanged.
- Note-off key 61 (voice 1) → voice_active bit1 cleared at T+2, no note_on, cur_key_* unchanged. Next note-on key 72 → voice 1.
- Note-off key 99 with no match → no state change, ev_ready back at T+2.
- all_notes_off during SETUP → the note_on strobe still completes, then voice_active=0 one cycle after returning to IDLE. Separately, assert reset_reg during SETUP → no note_on, all outputs at reset values immediately.
